// File: rtl/decoder24_hold_pkg.sv
// Shared types and helpers for the sequenced binary-to-one-hot decoder.
package decoder24_hold_pkg;

   // Output sequencer states: idle (no word shown) or holding a decoded word.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } dec_state_t;

   // A queued entry carries the enable bit above the binary code.
   function automatic int entry_width(input int n_in);
      return n_in + 1;
   endfunction

   // Hold counter counts HOLD-1 down to 0; keep at least one bit for HOLD=1.
   function automatic int cnt_width(input int hold);
      return (hold > 1) ? $clog2(hold) : 1;
   endfunction

endpackage

// File: rtl/decoder24_hold_sync_fifo.sv
// Synchronous FIFO with registered occupancy. Full/empty come from the
// registered level only, so no combinational path runs from pop to full.
module sync_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             push_ok, pop_ok;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign level   = level_q;

   // Next pointers wrap naturally (DEPTH is a power of two); level tracks push-pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
      else if (!push_ok && pop_ok) level_d = level_q - LW'(1);
   end

   // Control state: pointers and occupancy, flushed by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage: data only, never read while empty, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/decoder24_hold.sv
// Sequenced N-to-2^N decoder: buffers {enable, code} entries and shows each
// decoded one-hot word for exactly HOLD cycles, back-to-back when queued.
module decoder24_hold
   import decoder24_hold_pkg::*;
#(
   parameter int N_IN  = 2,
   parameter int HOLD  = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_IN-1:0]          in_code,
   input  logic                     in_en,
   output logic [2**N_IN-1:0]       out_onehot,
   output logic                     out_valid,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int ENTRY_W = entry_width(N_IN);
   localparam int OUT_W   = 2**N_IN;
   localparam int CNT_W   = cnt_width(HOLD);

   dec_state_t          state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [OUT_W-1:0]    onehot_q;
   logic                valid_q;

   logic [ENTRY_W-1:0]  head;
   logic                full, empty, push, pop;

   // Disabled entries decode to an all-zero word that is still held.
   function automatic logic [OUT_W-1:0] decode_entry(input logic [ENTRY_W-1:0] e);
      return e[ENTRY_W-1] ? (OUT_W'(1) << e[N_IN-1:0]) : '0;
   endfunction

   assign in_ready = !full;
   assign push     = in_valid && !full;
   // Take a new word when idle or on the last cycle of the current one.
   assign pop      = !empty && ((state_q == ST_IDLE) || (cnt_q == '0));

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({in_en, in_code}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // Output sequencer: load a word, count down its hold time, chain or go idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         onehot_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!empty) begin
                  onehot_q <= decode_entry(head);
                  valid_q  <= 1'b1;
                  cnt_q    <= CNT_W'(HOLD - 1);
                  state_q  <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else if (!empty) begin
                  onehot_q <= decode_entry(head);
                  cnt_q    <= CNT_W'(HOLD - 1);
               end else begin
                  onehot_q <= '0;
                  valid_q  <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_onehot = onehot_q;
   assign out_valid  = valid_q;

endmodule

// File: tb/tb_decoder24_hold.sv
// Randomized scoreboard bench for decoder24_hold, with HOLD=4 and HOLD=1 instances
// sharing one input stream. Each instance has its own acceptance model and monitor.
module tb_decoder24_hold;

   typedef struct {
      logic [3:0] w;
      int         t;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [1:0] in_code = 2'd0;
   logic       in_en = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : gi
      localparam int H = (g == 0) ? 4 : 1;

      logic       rdy, ov;
      logic [3:0] oh;
      logic [2:0] lvl;

      ent_t       sb[$];
      int         ecnt     = 0;
      int         flush_at = 0;
      logic       mrst     = 1'b1;
      int         pop_n    = 0;
      int         remain   = 0;
      logic [3:0] cur      = 4'd0;

      decoder24_hold #(.N_IN(2), .HOLD(H), .DEPTH(4)) dut (
         .clk        (clk),
         .rst        (rst),
         .in_valid   (in_valid),
         .in_ready   (rdy),
         .in_code    (in_code),
         .in_en      (in_en),
         .out_onehot (oh),
         .out_valid  (ov),
         .level      (lvl)
      );

      // Acceptance model: an entry is taken when valid and fewer than 4 are waiting.
      initial forever begin
         @(posedge clk);
         mrst = rst;
         if (rst) begin
            flush_at = sb.size();
         end else if (in_valid && (sb.size() - pop_n) < 4) begin
            sb.push_back('{w: (in_en ? 4'(1 << in_code) : 4'd0), t: ecnt});
         end
         ecnt++;
      end

      // Monitor: each word must appear one edge after acceptance and last H cycles.
      initial forever begin
         @(negedge clk);
         if (mrst) begin
            pop_n  = flush_at;
            remain = 0;
            chk($sformatf("h%0d_rst_valid", H), 32'(ov), 32'd0);
            chk($sformatf("h%0d_rst_onehot", H), 32'(oh), 32'd0);
            chk($sformatf("h%0d_rst_level", H), 32'(lvl), 32'd0);
            chk($sformatf("h%0d_rst_ready", H), 32'(rdy), 32'd1);
         end else begin
            if (remain > 0) begin
               remain--;
               chk($sformatf("h%0d_hold_valid", H), 32'(ov), 32'd1);
               chk($sformatf("h%0d_hold_word", H), 32'(oh), 32'(cur));
            end else if (pop_n < sb.size() && sb[pop_n].t + 1 < ecnt) begin
               cur = sb[pop_n].w;
               pop_n++;
               remain = H - 1;
               chk($sformatf("h%0d_new_valid", H), 32'(ov), 32'd1);
               chk($sformatf("h%0d_new_word", H), 32'(oh), 32'(cur));
            end else begin
               chk($sformatf("h%0d_idle_valid", H), 32'(ov), 32'd0);
               chk($sformatf("h%0d_idle_onehot", H), 32'(oh), 32'd0);
            end
            chk($sformatf("h%0d_level", H), 32'(lvl), 32'(sb.size() - pop_n));
            chk($sformatf("h%0d_ready", H), 32'(rdy), 32'((sb.size() - pop_n) < 4));
         end
      end
   end

   task automatic drive(input logic v, input logic [1:0] c, input logic e);
      @(negedge clk);
      in_valid = v;
      in_code  = c;
      in_en    = e;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0);
   endtask

   initial begin
      // reset held for two edges
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // single word
      drive(1'b1, 2'd2, 1'b1);
      idle(8);

      // burst of all four codes
      for (int c = 0; c < 4; c++) drive(1'b1, 2'(c), 1'b1);
      idle(20);

      // disabled entry still held
      drive(1'b1, 2'd3, 1'b0);
      idle(8);

      // keep valid high past full
      for (int i = 0; i < 12; i++) drive(1'b1, 2'(i % 4), 1'b1);
      idle(30);

      // reset during the second cycle of a word with more queued behind it
      drive(1'b1, 2'd1, 1'b1);
      drive(1'b1, 2'd2, 1'b1);
      drive(1'b1, 2'd3, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(10);

      // random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 4) != 0));
         rst = ($urandom_range(0, 299) == 0);
      end
      rst = 1'b0;
      idle(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
